// File: rtl/marie_sequencer_pkg.sv
// Shared definitions for the MARIE fetch/decode/execute sequencer.
//   - default word / address widths
//   - opcode encoding (IR[15:12]), FSM states, Skipcond selector, ALU ops
// No ports; imported by the interface, the ALU and the sequencer top.
package marie_sequencer_pkg;

  localparam int MARIE_ADDR_W = 12;
  localparam int MARIE_DATA_W = 16;

  typedef enum logic [3:0] {
    OP_JNS      = 4'h0,
    OP_LOAD     = 4'h1,
    OP_STORE    = 4'h2,
    OP_ADD      = 4'h3,
    OP_SUBT     = 4'h4,
    OP_INPUT    = 4'h5,
    OP_OUTPUT   = 4'h6,
    OP_HALT     = 4'h7,
    OP_SKIPCOND = 4'h8,
    OP_JUMP     = 4'h9,
    OP_CLEAR    = 4'hA,
    OP_ADDI     = 4'hB,
    OP_JUMPI    = 4'hC,
    OP_LOADI    = 4'hD,
    OP_STOREI   = 4'hE,
    OP_ILLEGAL  = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    S_F_ADDR,
    S_F_MEM,
    S_DECODE,
    S_IND_RD,
    S_EX_RD,
    S_EX_WR,
    S_EX_IO,
    S_EX_ALU,
    S_HALT
  } state_e;

  // Skipcond selector lives in IR[11:10]
  typedef enum logic [1:0] {
    SKIP_NEG   = 2'b00,
    SKIP_ZERO  = 2'b01,
    SKIP_POS   = 2'b10,
    SKIP_NEVER = 2'b11
  } skip_e;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB
  } alu_op_e;

endpackage

// File: rtl/marie_sequencer_if.sv
// Bus bundle between the MARIE sequencer and its environment.
//   mem_*  : word memory req/ack handshake (req/we/addr/wdata held until ack)
//   in_*   : Input-instruction data stream (valid/ready)
//   out_*  : Output-instruction data stream (valid/ready)
// Modports: master = sequencer side, slave = memory / IO side.
interface marie_sequencer_if
  import marie_sequencer_pkg::*;
#(
  parameter int ADDR_W = MARIE_ADDR_W,
  parameter int DATA_W = MARIE_DATA_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/marie_sequencer_alu.sv
// Combinational MARIE ALU.
//   op_i       : pass / add / subtract (wraps mod 2^DATA_W, no flags)
//   a_i        : accumulator
//   b_i        : memory buffer operand
//   skip_sel_i : Skipcond selector (IR[11:10])
//   res_o      : new accumulator value
//   skip_o     : Skipcond condition true for current AC
module marie_sequencer_alu
  import marie_sequencer_pkg::*;
#(
  parameter int DATA_W = MARIE_DATA_W
) (
  input  alu_op_e                   op_i,
  input  logic signed [DATA_W-1:0]  a_i,
  input  logic signed [DATA_W-1:0]  b_i,
  input  skip_e                     skip_sel_i,
  output logic signed [DATA_W-1:0]  res_o,
  output logic                      skip_o
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a_i[DATA_W-1];
  assign a_zero = (a_i == '0);

  always_comb begin
    res_o = b_i;
    case (op_i)
      ALU_ADD: res_o = a_i + b_i;
      ALU_SUB: res_o = a_i - b_i;
      default: res_o = b_i;
    endcase
  end

  always_comb begin
    skip_o = 1'b0;
    case (skip_sel_i)
      SKIP_NEG:   skip_o = a_neg;
      SKIP_ZERO:  skip_o = a_zero;
      SKIP_POS:   skip_o = !a_neg && !a_zero;
      default:    skip_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/marie_sequencer.sv
// MARIE fetch/decode/execute sequencer (PC, IR, MAR, MBR, AC).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : marie_sequencer_if.master (memory handshake + Input/Output streams)
//   ac, pc   : architectural accumulator and program counter
//   halted   : Halt (or illegal opcode) executed; only rst leaves this state
//   illegal  : opcode 0xF decoded
// Configuration macro MARIE_IO_EN: when defined, Input/Output stall in EX_IO on
// the valid/ready streams; when undefined they retire in DECODE as NOPs and the
// stream outputs are tied to zero.
module marie_sequencer
  import marie_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = MARIE_ADDR_W,
  parameter int                DATA_W   = MARIE_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  marie_sequencer_if.master  bus,
  output logic [DATA_W-1:0]  ac,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               illegal
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic signed [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0]        ir_q, ir_d;
  logic [ADDR_W-1:0]        mar_q, mar_d;
  logic signed [DATA_W-1:0] mbr_q, mbr_d;
  logic                     illegal_q, illegal_d;

  logic                     mem_req;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     in_ready;
  logic                     out_valid;

  opcode_e                  op;
  logic [ADDR_W-1:0]        ir_addr;
  alu_op_e                  alu_op;
  logic signed [DATA_W-1:0] alu_res;
  logic                     skip;

  assign op      = opcode_e'(ir_q[DATA_W-1 -: 4]);
  assign ir_addr = ir_q[ADDR_W-1:0];

  // Direct and indirect forms share one ALU step
  always_comb begin
    alu_op = ALU_PASS;
    case (op)
      OP_ADD, OP_ADDI: alu_op = ALU_ADD;
      OP_SUBT:         alu_op = ALU_SUB;
      default:         alu_op = ALU_PASS;
    endcase
  end

  marie_sequencer_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i       (alu_op),
    .a_i        (ac_q),
    .b_i        (mbr_q),
    .skip_sel_i (skip_e'(ir_q[ADDR_W-1 -: 2])),
    .res_o      (alu_res),
    .skip_o     (skip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_F_ADDR;
      pc_q      <= RESET_PC;
      ac_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mbr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ac_q      <= ac_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mbr_q     <= mbr_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake outputs decode straight from the state register, so a reset
  // (state -> F_ADDR) drops mem_req on the same edge and an ack that arrives
  // afterwards finds no access pending.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mbr_d     = mbr_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_F_ADDR: begin
        mar_d   = pc_q;
        state_d = S_F_MEM;
      end

      S_F_MEM: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        mar_d   = ir_addr;
        state_d = S_F_ADDR;
        case (op)
          OP_CLEAR:    ac_d = '0;
          OP_JUMP:     pc_d = ir_addr;
          OP_HALT:     state_d = S_HALT;
          OP_SKIPCOND: if (skip) pc_d = pc_q + 1'b1;
          OP_LOAD, OP_ADD, OP_SUBT: state_d = S_EX_RD;
          OP_STORE, OP_JNS:         state_d = S_EX_WR;
          OP_LOADI, OP_ADDI, OP_STOREI, OP_JUMPI: state_d = S_IND_RD;
          OP_INPUT, OP_OUTPUT: begin
`ifdef MARIE_IO_EN
            state_d = S_EX_IO;
`endif
          end
          OP_ILLEGAL: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
          default: state_d = S_F_ADDR;
        endcase
      end

      // Pointer fetch: JumpI finishes here, the others continue on the direct path
      S_IND_RD: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          if (op == OP_JUMPI) begin
            pc_d    = bus.mem_rdata[ADDR_W-1:0];
            state_d = S_F_ADDR;
          end else begin
            mar_d   = bus.mem_rdata[ADDR_W-1:0];
            state_d = (op == OP_STOREI) ? S_EX_WR : S_EX_RD;
          end
        end
      end

      S_EX_RD: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          mbr_d   = bus.mem_rdata;
          state_d = S_EX_ALU;
        end
      end

      S_EX_ALU: begin
        ac_d    = alu_res;
        state_d = S_F_ADDR;
      end

      // JnS stores the already-incremented PC as its return address
      S_EX_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = (op == OP_JNS) ? DATA_W'(pc_q) : ac_q;
        if (bus.mem_ack) begin
          if (op == OP_JNS) pc_d = mar_q + 1'b1;
          state_d = S_F_ADDR;
        end
      end

      S_EX_IO: begin
`ifdef MARIE_IO_EN
        if (op == OP_INPUT) begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            ac_d    = bus.in_data;
            state_d = S_F_ADDR;
          end
        end else begin
          out_valid = 1'b1;
          if (bus.out_ready) state_d = S_F_ADDR;
        end
`else
        state_d = S_F_ADDR;
`endif
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_F_ADDR;
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = mem_wdata;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
`ifdef MARIE_IO_EN
  assign bus.out_data  = out_valid ? ac_q : '0;
`else
  assign bus.out_data  = '0;
`endif

  assign ac      = ac_q;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_marie_sequencer.sv
// Self-checking bench for marie_sequencer (default build, MARIE_IO_EN undefined).
module tb_marie_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ac;
  logic [AW-1:0] pc;
  logic          halted;
  logic          illegal;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  marie_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  marie_sequencer #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (12'h000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ac      (ac),
    .pc      (pc),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: acks after ack_delay wait cycles, completes writes on the
  // ack cycle, and checks that a pending request does not change.
  initial begin : mem_model
    int            wc;
    logic          pend;
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [DW-1:0] p_wdata;
    wc = 0; pend = 1'b0; p_addr = '0; p_we = 1'b0; p_wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst || bus.mem_req !== 1'b1) begin
        wc = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (bus.mem_addr !== p_addr || bus.mem_we !== p_we || (p_we && bus.mem_wdata !== p_wdata)) begin
            errors++;
            $display("FAIL mem_stable: addr %h we %b wdata %h, required addr %h we %b wdata %h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, p_addr, p_we, p_wdata);
          end
        end
        if (wc >= ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
          wc = 0;
          pend = 1'b0;
        end else begin
          wc++;
          pend = 1'b1;
          p_addr = bus.mem_addr;
          p_we = bus.mem_we;
          p_wdata = bus.mem_wdata;
        end
      end
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset(input int d);
    ack_delay = d;
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic run_to_halt(input int maxc, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Instruction-level reference: executes ref_mem from address 0 until Halt or
  // the illegal opcode, returning final state and the expected cycle count.
  task automatic model_run(input int d, output logic [DW-1:0] m_ac, output logic [AW-1:0] m_pc,
                           output int m_cyc, output bit m_ill);
    logic [DW-1:0] ir, a;
    logic [AW-1:0] p, x, ptr;
    bit done;
    a = '0; p = '0; m_cyc = 0; m_ill = 1'b0; done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      ir = ref_mem[p];
      p = p + 1;
      x = ir[11:0];
      ptr = ref_mem[x][11:0];
      case (ir[15:12])
        4'h0: begin ref_mem[x] = {4'h0, p}; p = x + 1; m_cyc += 4 + 2*d; end
        4'h1: begin a = ref_mem[x];         m_cyc += 5 + 2*d; end
        4'h2: begin ref_mem[x] = a;         m_cyc += 4 + 2*d; end
        4'h3: begin a = a + ref_mem[x];     m_cyc += 5 + 2*d; end
        4'h4: begin a = a - ref_mem[x];     m_cyc += 5 + 2*d; end
        4'h5, 4'h6: m_cyc += 3 + d;
        4'h7: begin done = 1'b1; m_cyc += 3 + d; end
        4'h8: begin
          m_cyc += 3 + d;
          if ((x[11:10] == 2'd0 && $signed(a) < 0) ||
              (x[11:10] == 2'd1 && a == 0) ||
              (x[11:10] == 2'd2 && $signed(a) > 0)) p = p + 1;
        end
        4'h9: begin p = x;                  m_cyc += 3 + d; end
        4'hA: begin a = '0;                 m_cyc += 3 + d; end
        4'hB: begin a = a + ref_mem[ptr];   m_cyc += 6 + 3*d; end
        4'hC: begin p = ptr;                m_cyc += 4 + 2*d; end
        4'hD: begin a = ref_mem[ptr];       m_cyc += 6 + 3*d; end
        4'hE: begin ref_mem[ptr] = a;       m_cyc += 5 + 3*d; end
        default: begin m_ill = 1'b1; done = 1'b1; m_cyc += 3 + d; end
      endcase
    end
    m_ac = a;
    m_pc = p;
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    hold_reset();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem_if: req %b we %b addr %h wdata %h, required all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_io: in_ready %b out_valid %b out_data %h, required 0",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    checks++;
    if (ac !== 16'h0 || pc !== 12'h000 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_arch: ac %h pc %h halted %b illegal %b, required 0 0 0 0", ac, pc, halted, illegal);
    end
  endtask

  task automatic test_load();
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h1004);
    poke(12'h001, 16'h7000);
    poke(12'h004, 16'h1234);
    release_reset(0);
    step(4);
    checks++;
    if (ac !== 16'h0000) begin errors++; $display("FAIL load_ac_c4: got %h required 0000", ac); end
    step(1);
    checks++;
    if (ac !== 16'h1234) begin errors++; $display("FAIL load_ac_c5: got %h required 1234", ac); end
    checks++;
    if (pc !== 12'h001) begin errors++; $display("FAIL load_pc: got %h required 001", pc); end
  endtask

  task automatic test_store_wrap(input int d, input string tag);
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h1005);
    poke(12'h001, 16'h3006);
    poke(12'h002, 16'h2007);
    poke(12'h003, 16'h7000);
    poke(12'h005, 16'hFFFF);
    poke(12'h006, 16'h0002);
    release_reset(d);
    step(14 + 6*d);
    checks++;
    if (mem[7] !== 16'h0001) begin errors++; $display("FAIL %s_m7: got %h required 0001", tag, mem[7]); end
    checks++;
    if (pc !== 12'h003) begin errors++; $display("FAIL %s_pc: got %h required 003", tag, pc); end
    checks++;
    if (ac !== 16'h0001) begin errors++; $display("FAIL %s_ac: got %h required 0001", tag, ac); end
  endtask

  task automatic test_loadi();
    hold_reset();
    clear_mem();
    poke(12'h000, 16'hD008);
    poke(12'h001, 16'h7000);
    poke(12'h008, 16'h0020);
    poke(12'h020, 16'hBEEF);
    release_reset(0);
    step(5);
    checks++;
    if (ac !== 16'h0000) begin errors++; $display("FAIL loadi_ac_c5: got %h required 0000", ac); end
    step(1);
    checks++;
    if (ac !== 16'hBEEF) begin errors++; $display("FAIL loadi_ac_c6: got %h required BEEF", ac); end
  endtask

  task automatic test_skip_jns();
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h8400);
    poke(12'h001, 16'h7000);
    poke(12'h002, 16'h0010);
    poke(12'h011, 16'h7000);
    release_reset(0);
    step(3);
    checks++;
    if (pc !== 12'h002) begin errors++; $display("FAIL skip_pc: got %h required 002", pc); end
    step(4);
    checks++;
    if (mem[12'h010] !== 16'h0003) begin errors++; $display("FAIL jns_ret: got %h required 0003", mem[12'h010]); end
    checks++;
    if (pc !== 12'h011) begin errors++; $display("FAIL jns_pc: got %h required 011", pc); end
  endtask

  task automatic test_jump_illegal();
    logic [DW-1:0] e_ac;
    logic [AW-1:0] e_pc;
    int e_cyc, cyc, bad;
    bit e_ill;
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h1020); poke(12'h001, 16'h9005); poke(12'h002, 16'h7000);
    poke(12'h005, 16'hC021);
    poke(12'h040, 16'hE022); poke(12'h041, 16'h8000); poke(12'h042, 16'h7000);
    poke(12'h043, 16'hB023); poke(12'h044, 16'h8400); poke(12'h045, 16'h7000);
    poke(12'h046, 16'h4025); poke(12'h047, 16'h8800); poke(12'h048, 16'hA000);
    poke(12'h049, 16'h8C00); poke(12'h04A, 16'hF000);
    poke(12'h020, 16'h8001); poke(12'h021, 16'h0040); poke(12'h022, 16'h0050);
    poke(12'h023, 16'h0024); poke(12'h024, 16'h7FFF); poke(12'h025, 16'h0001);
    model_run(1, e_ac, e_pc, e_cyc, e_ill);
    release_reset(1);
    run_to_halt(2000, cyc);
    checks++;
    if (cyc !== e_cyc) begin errors++; $display("FAIL jmp_cycles: got %0d required %0d", cyc, e_cyc); end
    checks++;
    if (ac !== e_ac || pc !== e_pc) begin
      errors++; $display("FAIL jmp_state: ac %h pc %h, required ac %h pc %h", ac, pc, e_ac, e_pc);
    end
    checks++;
    if (illegal !== e_ill || halted !== 1'b1) begin
      errors++; $display("FAIL jmp_illegal: illegal %b halted %b, required %b 1", illegal, halted, e_ill);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL jmp_mem: %0d words differ, required 0", bad); end
  endtask

  task automatic test_io_nop();
    int cyc, bad;
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h5000);
    poke(12'h001, 16'h6000);
    poke(12'h002, 16'h7000);
    release_reset(0);
    cyc = 0; bad = 0;
    while (halted !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0) bad++;
    end
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL io_cycles: got %0d required 9", cyc); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL io_outputs: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_halt_reset();
    int cyc, bad;
    hold_reset();
    clear_mem();
    poke(12'h000, 16'h7000);
    release_reset(0);
    step(3);
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b0) begin
      errors++; $display("FAIL halt_flag: halted %b illegal %b, required 1 0", halted, illegal);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (bus.mem_req !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold: cycle %0d mem_req %b halted %b, required 0 1", i, bus.mem_req, halted);
      end
    end

    hold_reset();
    clear_mem();
    poke(12'h000, 16'h1004);
    poke(12'h001, 16'h1005);
    poke(12'h002, 16'h7000);
    poke(12'h004, 16'h1234);
    poke(12'h005, 16'h5678);
    release_reset(3);
    step(13);
    checks++;
    if (ac !== 16'h1234 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL pre_rst: ac %h mem_req %b, required 1234 1", ac, bus.mem_req);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (pc !== 12'h000 || ac !== 16'h0000 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL mid_rst: pc %h ac %h mem_req %b, required 000 0000 0", pc, ac, bus.mem_req);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h000) begin
      errors++; $display("FAIL refetch: mem_req %b addr %h, required 1 000", bus.mem_req, bus.mem_addr);
    end
    run_to_halt(200, cyc);
    bad = (halted === 1'b1) ? 0 : 1;
    checks++;
    if (ac !== 16'h5678 || bad != 0) begin
      errors++; $display("FAIL rerun: ac %h halted %b, required 5678 1", ac, halted);
    end
  endtask

  task automatic test_random();
    logic [3:0]    ops [11];
    logic [3:0]    o;
    logic [DW-1:0] w, e_ac;
    logic [AW-1:0] e_pc;
    int e_cyc, cyc, bad, d;
    bit e_ill;
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hA, 4'hB, 4'hD, 4'hE, 4'h5, 4'h6};
    for (int r = 0; r < 6; r++) begin
      hold_reset();
      clear_mem();
      for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), 16'($urandom));
      for (int i = 0; i < 4; i++) poke(12'h110 + 12'(i), 16'h0100 + 16'($urandom_range(0, 15)));
      for (int i = 0; i < 12; i++) begin
        o = ops[$urandom_range(0, 10)];
        case (o)
          4'h1, 4'h2, 4'h3, 4'h4: w = {o, 12'h100 + 12'($urandom_range(0, 15))};
          4'hB, 4'hD, 4'hE:       w = {o, 12'h110 + 12'($urandom_range(0, 3))};
          4'h8:                   w = {o, 2'($urandom_range(0, 3)), 10'h000};
          default:                w = {o, 12'h000};
        endcase
        poke(12'(i), w);
      end
      poke(12'd12, 16'h7000);
      poke(12'd13, 16'h7000);
      d = $urandom_range(0, 2);
      model_run(d, e_ac, e_pc, e_cyc, e_ill);
      release_reset(d);
      run_to_halt(3000, cyc);
      checks++;
      if (cyc !== e_cyc) begin errors++; $display("FAIL rnd%0d_cycles: got %0d required %0d", r, cyc, e_cyc); end
      checks++;
      if (ac !== e_ac) begin errors++; $display("FAIL rnd%0d_ac: got %h required %h", r, ac, e_ac); end
      checks++;
      if (pc !== e_pc) begin errors++; $display("FAIL rnd%0d_pc: got %h required %h", r, pc, e_pc); end
      bad = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rnd%0d_mem: %0d words differ, required 0", r, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wrap(0, "store");
    test_store_wrap(3, "wait3");
    test_loadi();
    test_skip_jns();
    test_jump_illegal();
    test_io_nop();
    test_halt_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
